// File: rtl/led_seq_defs.sv
// Shared definitions for the LED sequencer: register word indices, mode encodings
// and the LED reset pattern.
package led_seq_defs;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_PERIOD = 4'd1;
    localparam logic [3:0] REG_STATIC = 4'd2;
    localparam logic [3:0] REG_LEN    = 4'd3;
    localparam logic [3:0] REG_STATUS = 4'd4;

    localparam logic [7:0] LED_RESET = 8'hFF;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_TABLE  = 2'd3
    } mode_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step timer: counts 0..period while enabled and flags the terminal cycle as a step.
module led_step_timer #(
    parameter int PW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic [PW-1:0] period,
    output logic          step
);

    logic [PW-1:0] count_reg;

    assign step = en && (count_reg == period);

    // Count resets after the step cycle, so PERIOD=0 steps on every edge.
    always_ff @(negedge clk) begin
        if (rst || clear || !en || step) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Memory-mapped LED pattern sequencer: static, rotate, blink and table modes,
// stepped by a programmable period. State advances on the falling clock edge.
module led_sequencer
    import led_seq_defs::*;
#(
    parameter int PW = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [31:0] daddr,
    input  logic        drw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [7:0]  leds
);

    logic          ctrl_en_reg;
    mode_t         ctrl_mode_reg;
    logic [PW-1:0] period_reg;
    logic [7:0]    static_reg;
    logic [2:0]    len_reg;
    logic [2:0]    idx_reg;
    logic [2:0]    idx_next;
    logic [7:0]    leds_reg;
    logic [7:0]    leds_next;
    logic [7:0][7:0] table_val;

    logic [3:0] widx;
    logic       wr_en;
    logic       ctrl_wr;
    logic       period_wr;
    logic       static_wr;
    logic       len_wr;
    logic       table_wr;
    logic       restart;
    logic       step;
    logic       en_new;
    mode_t      mode_new;
    logic [7:0] static_new;
    logic [31:0] period_ext;
    logic        unused_bits;

    assign widx      = daddr[5:2];
    assign wr_en     = de && drw && !rst;
    assign ctrl_wr   = wr_en && (widx == REG_CTRL);
    assign period_wr = wr_en && (widx == REG_PERIOD);
    assign static_wr = wr_en && (widx == REG_STATIC);
    assign len_wr    = wr_en && (widx == REG_LEN);
    assign table_wr  = wr_en && widx[3];
    assign restart   = ctrl_wr || period_wr || len_wr;

    // Post-write register values, so a write's effect lands on the same edge.
    assign en_new     = ctrl_wr ? din[0] : ctrl_en_reg;
    assign mode_new   = ctrl_wr ? mode_t'(din[2:1]) : ctrl_mode_reg;
    assign static_new = static_wr ? din[7:0] : static_reg;

    assign unused_bits = ^{daddr[31:6], daddr[1:0], din};

    led_step_timer #(.PW(PW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (restart),
        .en     (ctrl_en_reg),
        .period (period_reg),
        .step   (step)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_table
            logic [7:0] entry_reg;
            always_ff @(negedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (table_wr && (widx[2:0] == 3'(gi))) begin
                    entry_reg <= din[7:0];
                end
            end
            assign table_val[gi] = entry_reg;
        end
    endgenerate

    // Any effective register write wins over a coinciding step.
    always_comb begin
        leds_next = leds_reg;
        idx_next  = idx_reg;
        if (!en_new) begin
            leds_next = static_new;
            idx_next  = 3'd0;
        end else if (restart) begin
            idx_next  = 3'd0;
            leds_next = (mode_new == MODE_TABLE) ? table_val[0] : static_new;
        end else if (static_wr) begin
            if (ctrl_mode_reg != MODE_TABLE) begin
                leds_next = din[7:0];
            end
        end else if (table_wr) begin
            if (ctrl_mode_reg == MODE_TABLE && widx[2:0] == idx_reg) begin
                leds_next = din[7:0];
            end
        end else if (step) begin
            case (ctrl_mode_reg)
                MODE_ROTATE: leds_next = rotl8(leds_reg);
                MODE_BLINK:  leds_next = (leds_reg == 8'h00) ? static_reg : 8'h00;
                MODE_TABLE: begin
                    idx_next  = (idx_reg == len_reg) ? 3'd0 : idx_reg + 3'd1;
                    leds_next = table_val[idx_next];
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            ctrl_en_reg   <= 1'b0;
            ctrl_mode_reg <= MODE_STATIC;
            period_reg    <= '0;
            static_reg    <= LED_RESET;
            len_reg       <= 3'd0;
            idx_reg       <= 3'd0;
            leds_reg      <= LED_RESET;
        end else begin
            if (ctrl_wr) begin
                ctrl_en_reg   <= din[0];
                ctrl_mode_reg <= mode_t'(din[2:1]);
            end
            if (period_wr) begin
                period_reg <= din[PW-1:0];
            end
            if (static_wr) begin
                static_reg <= din[7:0];
            end
            if (len_wr) begin
                len_reg <= din[2:0];
            end
            idx_reg  <= idx_next;
            leds_reg <= leds_next;
        end
    end

    assign leds = leds_reg;

    always_comb begin
        period_ext = '0;
        period_ext[PW-1:0] = period_reg;
    end

    // STATUS keeps idx above the running bit so it never overlaps the LED byte.
    always_comb begin
        dout = 32'h0;
        if (de) begin
            case (widx)
                REG_CTRL:   dout = {29'd0, ctrl_mode_reg, ctrl_en_reg};
                REG_PERIOD: dout = period_ext;
                REG_STATIC: dout = {24'd0, static_reg};
                REG_LEN:    dout = {29'd0, len_reg};
                REG_STATUS: dout = {17'd0, idx_reg, 3'd0, ctrl_en_reg, leds_reg};
                default: begin
                    if (widx[3]) begin
                        dout = {24'd0, table_val[widx[2:0]]};
                    end
                end
            endcase
        end
    end

endmodule
